// File: rtl/con_feeder_pkg.sv
// Shared constants and FSM state type for the convolution feeder and its engine.
package con_feeder_pkg;

  localparam int unsigned N_CORE    = 9;
  localparam int unsigned N_PICS    = 49;
  localparam int unsigned N_RES     = 25;
  localparam int unsigned DRAIN_MAX = 64;
  localparam int unsigned DW        = 16;
  localparam int unsigned LD_AW     = 6;
  localparam int unsigned RD_AW     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/con_feeder_if.sv
// Word stream to the convolution engine and its result/finish return path.
interface con_feeder_if;

  logic                         con_ena;
  logic [con_feeder_pkg::DW-1:0] con_data;
  logic                         con_valid;
  logic [con_feeder_pkg::DW-1:0] con_result;
  logic                         con_finish;

  modport master (
    output con_ena, con_data,
    input  con_valid, con_result, con_finish
  );

  modport slave (
    input  con_ena, con_data,
    output con_valid, con_result, con_finish
  );

endinterface

// File: rtl/con_feeder_ram.sv
// Stream buffer: synchronous write, asynchronous read, contents not reset.
module con_feeder_ram #(
  parameter int unsigned DEPTH = 58,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/con_feeder.sv
// Streams kernel+picture words to a convolution engine, collects its results
// and reports completion with a count/timeout error flag.
module con_feeder #(
  parameter int unsigned N_CORE    = con_feeder_pkg::N_CORE,
  parameter int unsigned N_PICS    = con_feeder_pkg::N_PICS,
  parameter int unsigned N_RES     = con_feeder_pkg::N_RES,
  parameter int unsigned DRAIN_MAX = con_feeder_pkg::DRAIN_MAX
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ld_we,
  input  logic [con_feeder_pkg::LD_AW-1:0]  ld_addr,
  input  logic [con_feeder_pkg::DW-1:0]     ld_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  con_feeder_if.master                      con,
  input  logic [con_feeder_pkg::RD_AW-1:0]  rd_addr,
  output logic [con_feeder_pkg::DW-1:0]     rd_data
);

  typedef con_feeder_pkg::state_e state_e;

  localparam int unsigned DW    = con_feeder_pkg::DW;
  localparam int unsigned LD_AW = con_feeder_pkg::LD_AW;
  localparam int unsigned TOTAL = N_CORE + N_PICS;
  localparam int unsigned IW    = $clog2(TOTAL + 1);
  localparam int unsigned CW    = $clog2(N_RES + 1);
  localparam int unsigned TW    = $clog2(DRAIN_MAX + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ena_q, ena_d;
  logic [DW-1:0]   data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            arm_q, arm_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            cap_we;

  logic            ram_we;
  logic [LD_AW-1:0] ram_raddr;
  logic [DW-1:0]   ram_rdata;
  logic [DW-1:0]   res_q [N_RES];

  // Host loads are only accepted while idle so a running stream stays intact.
  assign ram_we    = ld_we && (state_q == con_feeder_pkg::ST_IDLE) && (32'(ld_addr) < TOTAL);
  assign ram_raddr = (state_q == con_feeder_pkg::ST_IDLE) ? '0 : LD_AW'(idx_q);

  con_feeder_ram #(
    .DEPTH (TOTAL),
    .DW    (DW),
    .AW    (LD_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= con_feeder_pkg::ST_IDLE;
      idx_q   <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ena_d   = 1'b0;
    data_d  = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    arm_d   = 1'b0;
    tmr_d   = tmr_q;
    cap_we  = 1'b0;

    // A capture armed by the previous cycle's con_valid lands now.
    if (arm_q && (state_q == con_feeder_pkg::ST_STREAM || state_q == con_feeder_pkg::ST_DRAIN)) begin
      if (cnt_q < CW'(N_RES)) begin
        cap_we = 1'b1;
        cnt_d  = cnt_q + CW'(1);
      end else begin
        err_d  = 1'b1;
      end
    end

    unique case (state_q)
      con_feeder_pkg::ST_IDLE: begin
        if (start) begin
          state_d = con_feeder_pkg::ST_STREAM;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          ena_d   = 1'b1;
          data_d  = ram_rdata;
          idx_d   = IW'(1);
          tmr_d   = '0;
        end
      end
      con_feeder_pkg::ST_STREAM: begin
        arm_d = con.con_valid;
        if (idx_q < IW'(TOTAL)) begin
          ena_d  = 1'b1;
          data_d = ram_rdata;
          idx_d  = idx_q + IW'(1);
        end else begin
          state_d = con_feeder_pkg::ST_DRAIN;
          tmr_d   = '0;
        end
      end
      con_feeder_pkg::ST_DRAIN: begin
        arm_d = con.con_valid;
        if (con.con_finish) begin
          state_d = con_feeder_pkg::ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (cnt_d != CW'(N_RES)) err_d = 1'b1;
        end else if (tmr_q == TW'(DRAIN_MAX - 1)) begin
          state_d = con_feeder_pkg::ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      con_feeder_pkg::ST_DONE: begin
        state_d = con_feeder_pkg::ST_IDLE;
      end
      default: state_d = con_feeder_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cap_we) res_q[cnt_q] <= con.con_result;
  end

  assign rd_data = (32'(rd_addr) < N_RES) ? res_q[rd_addr] : '0;

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign con.con_ena  = ena_q;
  assign con.con_data = data_q;

endmodule

// File: tb/tb_con_feeder.sv
// Directed bench for con_feeder: streaming order, result capture, count/timeout
// errors, ignored mid-run requests and asynchronous abort.
module tb_con_feeder;

  logic        clk;
  logic        rst_n;
  logic        ld_we;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  con_feeder_if bus ();

  con_feeder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .con     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks all 58 words; at word inj_k a start and a load are injected.
  task automatic stream_words(input int inj_k);
    for (int k = 0; k < 58; k++) begin
      check_eq("stream_ena", 32'(bus.con_ena), 32'd1);
      check_eq("stream_data", 32'(bus.con_data), 32'(k + 1));
      if (k == inj_k) begin
        start   = 1'b1;
        ld_we   = 1'b1;
        ld_addr = 6'd0;
        ld_data = 16'hBEEF;
      end
      @(negedge clk);
      start = 1'b0;
      ld_we = 1'b0;
    end
    check_eq("stream_end_ena", 32'(bus.con_ena), 32'd0);
    check_eq("stream_end_data", 32'(bus.con_data), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd1);
  endtask

  // Engine model: n valid pulses, each result presented the cycle after its valid.
  task automatic engine(input int n, input int base, input bit fin);
    for (int i = 0; i <= n; i++) begin
      bus.con_valid  = (i < n);
      bus.con_result = (i > 0) ? 16'(base + i - 1) : 16'd0;
      @(negedge clk);
    end
    bus.con_valid  = 1'b0;
    bus.con_result = 16'd0;
    if (fin) begin
      bus.con_finish = 1'b1;
      @(negedge clk);
      bus.con_finish = 1'b0;
    end
  endtask

  task automatic check_result(input int idx, input int exp);
    rd_addr = 5'(idx);
    #1;
    check_eq("result", 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned done_seen;

    rst_n          = 1'b0;
    ld_we          = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    start          = 1'b0;
    rd_addr        = '0;
    bus.con_valid  = 1'b0;
    bus.con_result = '0;
    bus.con_finish = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ena", 32'(bus.con_ena), 32'd0);
    check_eq("rst_data", 32'(bus.con_data), 32'd0);
    rst_n = 1'b1;

    // Load buffer[i] = i+1, plus out-of-range writes that must be dropped.
    for (int i = 0; i < 58; i++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = 6'(i); ld_data = 16'(i + 1);
    end
    @(negedge clk);
    ld_addr = 6'd58; ld_data = 16'hDEAD;
    @(negedge clk);
    ld_addr = 6'd63;
    @(negedge clk);
    ld_we = 1'b0;

    // Full run: 25 results then finish.
    do_start();
    check_eq("busy_after_start", 32'(busy), 32'd1);
    stream_words(-1);
    engine(25, 100, 1'b1);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_err", 32'(err), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 25; i++) check_result(i, 100 + i);

    // Short result count, with start and load injected mid-stream.
    do_start();
    stream_words(10);
    engine(24, 300, 1'b1);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_err", 32'(err), 32'd1);
    @(negedge clk);
    check_eq("t2_err_held", 32'(err), 32'd1);
    check_eq("t2_idle_busy", 32'(busy), 32'd0);
    check_result(0, 300);
    check_result(23, 323);
    check_result(24, 124);

    // No finish: timeout 64 cycles after drain entry; buffer[0] still 1.
    do_start();
    check_eq("t3_err_cleared", 32'(err), 32'd0);
    stream_words(-1);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_timeout_cycles", n, 32'd64);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);

    // Asynchronous abort at word 20.
    do_start();
    for (int k = 0; k < 20; k++) @(negedge clk);
    check_eq("t4_word20", 32'(bus.con_data), 32'd21);
    rst_n = 1'b0;
    #1;
    check_eq("t4_abort_ena", 32'(bus.con_ena), 32'd0);
    check_eq("t4_abort_data", 32'(bus.con_data), 32'd0);
    check_eq("t4_abort_busy", 32'(busy), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_eq("t4_no_done", done_seen, 32'd0);

    // Restart from word 0, with one result too many.
    do_start();
    stream_words(-1);
    engine(26, 200, 1'b1);
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_err_overflow", 32'(err), 32'd1);
    @(negedge clk);
    check_result(0, 200);
    check_result(24, 224);
    rd_addr = 5'd30;
    #1;
    check_eq("rd_out_of_range", 32'(rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/con_feeder.md
CON_FEEDER -- requirements
Module: con_feeder

Interface
REQ-001 Parameters: N_CORE, default 9, number of kernel words; N_PICS, default 49, number of picture words; N_RES, default 25, number of expected results; DRAIN_MAX, default 64, cycles to wait for finish.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ld_we  input  1  host load strobe for stream buffer.
REQ-005 ld_addr  input  6  stream buffer word address, 0..N_CORE+N_PICS-1.
REQ-006 ld_data  input  16  stream buffer write data.
REQ-007 start  input  1  single-cycle request to run one convolution.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 err  output  1  result-count or timeout error, valid with done, held until next start.
REQ-011 con_ena  output  1  word-valid to convolution engine.
REQ-012 con_data  output  16  stream word to engine.
REQ-013 con_valid  input  1  engine result-valid.
REQ-014 con_result  input  16  engine result.
REQ-015 con_finish  input  1  engine end-of-run.
REQ-016 rd_addr  input  5  result buffer read address, 0..N_RES-1.
REQ-017 rd_data  output  16  result buffer read data, combinational from rd_addr.

Function
REQ-018 States IDLE, STREAM, DRAIN, DONE; encoding local.
REQ-019 IDLE: ld_we=1 with ld_addr < N_CORE+N_PICS writes ld_data to buffer[ld_addr]; out-of-range writes dropped.
REQ-020 ld_we SHALL be ignored in any state other than IDLE.
REQ-021 IDLE with start=1 -> STREAM next cycle; clears result count and err; busy=1 from that cycle.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 STREAM: con_ena=1 for exactly N_CORE+N_PICS consecutive cycles, con_data=buffer[k] on the k-th cycle, k from 0; words 0..N_CORE-1 are the kernel, row-major; the remainder are picture words in buffer order.
REQ-024 After the last word: con_ena=0 and con_data=0 the next cycle; state -> DRAIN.
REQ-025 con_data SHALL be 0 whenever con_ena=0.
REQ-026 Result capture in STREAM and DRAIN: a cycle with con_valid=1 arms a capture; on the following cycle con_result is written to result[count] and count increments.
REQ-027 Captures with count >= N_RES SHALL be dropped and set err.
REQ-028 DRAIN exit on con_finish=1 -> DONE:
  - err additionally set if count != N_RES, counting a capture landing in that same cycle.
REQ-029 DRAIN exit when DRAIN_MAX cycles elapse without con_finish -> DONE with err=1.
REQ-030 DONE lasts one cycle: done=1, busy=0; then -> IDLE.
REQ-031 con_valid and con_finish in IDLE or DONE SHALL be ignored.
REQ-032 rd_data reflects the last written result; reads are legal in any state.

Reset
REQ-033 rst_n low: state IDLE, busy=0, done=0, err=0, con_ena=0, con_data=0, result count=0, capture arm=0, drain timer=0.
REQ-034 Buffer and result contents are not reset.
REQ-035 rst_n asserted mid-run aborts immediately; no done pulse is produced.

Structure
REQ-036 A shared package holds the state enum, N_CORE, N_PICS and N_RES; the engine and this block both use it.
REQ-037 One sub-module, con_feeder_ram: the 58x16 stream buffer with a synchronous write and asynchronous read port.
REQ-038 The result buffer is a flat register array inside con_feeder.

Verification
REQ-039 Load buffer[i]=i+1; pulse start -> con_ena high for 58 cycles, con_data 1..58 in order, then 0.
REQ-040 Engine model gives 25 con_valid pulses with results 100..124, then con_finish -> result[0..24]=100..124, done for 1 cycle, err=0.
REQ-041 Engine model gives only 24 results then con_finish -> done=1, err=1.
REQ-042 con_finish never asserted -> done exactly 64 cycles after DRAIN entry, err=1.
REQ-043 start and ld_we pulsed mid-STREAM -> no restart; buffer unchanged; stream sequence intact.
REQ-044 rst_n low at STREAM word 20 -> con_ena=0 asynchronously; no done; a subsequent start streams from word 0.
